// File: rtl/ttt_board_engine.sv
// N x N two-player tic-tac-toe engine: register board, turn/result FSM and a
// one-cycle registered RGB pixel path for the VGA renderer.
module ttt_board_engine #(
  parameter int BOARD_N     = 3,
  parameter int CELL_PX     = 100,
  parameter int MARK_MARGIN = 25,
  parameter int BLINK_BITS  = 24
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       vga_on,
  input  logic [9:0] Pixel_X,
  input  logic [8:0] Pixel_Y,
  input  logic [7:0] square_num,
  input  logic       place,
  input  logic       new_game,
  output logic       vga_red,
  output logic       vga_green,
  output logic       vga_blue,
  output logic       player_turn,
  output logic       player_1_win,
  output logic       player_2_win,
  output logic       draw,
  output logic       game_over,
  output logic [1:0] dbg_state
);

  localparam int NN       = BOARD_N * BOARD_N;
  localparam int LW       = 4;
  localparam int BOARD_PX = BOARD_N * CELL_PX;

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [2*NN-1:0]       board, board_nx;
  logic                  turn_nx, p1_nx, p2_nx, draw_nx;
  logic [LW-1:0]         win_line, win_line_nx;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  phase;
  logic [1:0]            cur_code;
  logic                  any_win, any_empty, line_hit;
  logic [LW-1:0]         win_id;
  logic                  sq_ok;
  int                    sq_idx;
  logic [1:0]            sq_cell;

  // Line ids: rows 0..N-1, columns N..2N-1, main diagonal 2N, anti-diagonal 2N+1.
  function automatic logic on_line(input int l, input int r, input int c);
    if (l < BOARD_N)            return r == l;
    else if (l < 2 * BOARD_N)   return c == l - BOARD_N;
    else if (l == 2 * BOARD_N)  return r == c;
    else                        return r + c == BOARD_N - 1;
  endfunction

  assign phase     = blink_cnt[BLINK_BITS-1];
  assign cur_code  = player_turn ? 2'b10 : 2'b01;
  assign game_over = (state == S_OVER);
  assign dbg_state = state;

  always_comb begin
    sq_ok   = (square_num != 8'd0) && (int'(square_num) <= NN);
    sq_idx  = sq_ok ? int'(square_num) - 1 : 0;
    sq_cell = board[2*sq_idx +: 2];
  end

  // Lines are scanned high to low so the lowest matching id is latched.
  always_comb begin
    any_win   = 1'b0;
    win_id    = '0;
    any_empty = 1'b0;
    line_hit  = 1'b0;
    for (int i = 0; i < NN; i++)
      if (board[2*i +: 2] == 2'b00) any_empty = 1'b1;
    for (int l = 2 * BOARD_N + 1; l >= 0; l--) begin
      line_hit = 1'b1;
      for (int r = 0; r < BOARD_N; r++)
        for (int c = 0; c < BOARD_N; c++)
          if (on_line(l, r, c) && board[2*(r*BOARD_N+c) +: 2] != cur_code)
            line_hit = 1'b0;
      if (line_hit) begin
        any_win = 1'b1;
        win_id  = LW'(l);
      end
    end
  end

  // place/new_game are single-cycle strobes with no back-pressure: a place is
  // taken only in PLAY on a legal empty cell, otherwise it is dropped.
  always_comb begin
    state_nx    = state;
    board_nx    = board;
    turn_nx     = player_turn;
    p1_nx       = player_1_win;
    p2_nx       = player_2_win;
    draw_nx     = draw;
    win_line_nx = win_line;
    if (new_game) begin
      state_nx    = S_PLAY;
      board_nx    = '0;
      turn_nx     = 1'b0;
      p1_nx       = 1'b0;
      p2_nx       = 1'b0;
      draw_nx     = 1'b0;
      win_line_nx = '0;
    end else begin
      case (state)
        S_PLAY: begin
          if (place && sq_ok && sq_cell == 2'b00) begin
            board_nx[2*sq_idx +: 2] = cur_code;
            state_nx                = S_CHECK;
          end
        end
        S_CHECK: begin
          if (any_win) begin
            if (player_turn) p2_nx = 1'b1;
            else             p1_nx = 1'b1;
            win_line_nx = win_id;
            state_nx    = S_OVER;
          end else if (!any_empty) begin
            draw_nx  = 1'b1;
            state_nx = S_OVER;
          end else begin
            turn_nx  = ~player_turn;
            state_nx = S_PLAY;
          end
        end
        S_OVER:  state_nx = S_OVER;
        default: state_nx = S_PLAY;
      endcase
    end
  end

  int         px, py, col, row, x_off, y_off, pidx;
  logic       on_board, grid, in_mark, on_win;
  logic [1:0] p_cell;
  logic [2:0] rgb_nx;

  always_comb begin
    px   = int'(Pixel_X);
    py   = int'(Pixel_Y);
    col  = 0;
    row  = 0;
    grid = 1'b0;
    for (int k = 1; k < BOARD_N; k++) begin
      if (px >= k * CELL_PX) col = col + 1;
      if (py >= k * CELL_PX) row = row + 1;
      if (px == k * CELL_PX || py == k * CELL_PX) grid = 1'b1;
    end
    on_board = (px < BOARD_PX) && (py < BOARD_PX);
    x_off    = px - col * CELL_PX;
    y_off    = py - row * CELL_PX;
    in_mark  = (x_off >= MARK_MARGIN) && (x_off <= CELL_PX - MARK_MARGIN) &&
               (y_off >= MARK_MARGIN) && (y_off <= CELL_PX - MARK_MARGIN);
    pidx     = row * BOARD_N + col;
    p_cell   = board[2*pidx +: 2];
    on_win   = (player_1_win || player_2_win) && on_line(int'(win_line), row, col);
    rgb_nx   = 3'b011;
    if (!vga_on || !on_board || grid)
      rgb_nx = 3'b000;
    else if (in_mark && p_cell != 2'b00) begin
      if (state == S_OVER && on_win && phase) rgb_nx = 3'b111;
      else if (p_cell == 2'b01)              rgb_nx = 3'b010;
      else                                   rgb_nx = 3'b100;
    end else if (state == S_PLAY && int'(square_num) == pidx + 1 && phase)
      rgb_nx = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= S_PLAY;
      board        <= '0;
      player_turn  <= 1'b0;
      player_1_win <= 1'b0;
      player_2_win <= 1'b0;
      draw         <= 1'b0;
      win_line     <= '0;
      blink_cnt    <= '0;
      {vga_red, vga_green, vga_blue} <= 3'b000;
    end else begin
      state        <= state_nx;
      board        <= board_nx;
      player_turn  <= turn_nx;
      player_1_win <= p1_nx;
      player_2_win <= p2_nx;
      draw         <= draw_nx;
      win_line     <= win_line_nx;
      blink_cnt    <= blink_cnt + 1'b1;
      {vga_red, vga_green, vga_blue} <= rgb_nx;
    end
  end

endmodule
